// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage between instruction memory and the
// decode pipeline register. Owns the fetch PC and issues word-addressed reads
// with at most one read outstanding. Returned instructions are buffered, each
// with its PC+1, in a DEPTH-entry FIFO.
//
// Optional build macro: FQ_BYPASS_EN. When it is defined, a response that
// arrives while the queue is empty is presented at the output in the same
// cycle. When it is not defined, every response goes through queue storage.
//
// Ports:
//   CLK, RST        clock, synchronous active-high reset
//   redirect        flush the queue and restart fetch at redirect_pc
//   redirect_pc     new fetch PC (word address)
//   imem_req        read request valid
//   imem_addr       read word address (fetch PC)
//   imem_ack        memory accepts the request this cycle
//   imem_rvalid     read data valid
//   imem_rdata      read data
//   out_valid       head entry valid
//   out_instr       head instruction
//   out_pcplus1     head PC+1
//   out_ready       decode consumes the head entry
//   count           number of occupied entries, 0..DEPTH
module fetch_queue #(
    parameter int unsigned M        = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned AW       = 2,
    parameter logic [M-1:0] RESET_PC = '0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          redirect,
    input  logic [M-1:0]  redirect_pc,
    output logic          imem_req,
    output logic [M-1:0]  imem_addr,
    input  logic          imem_ack,
    input  logic          imem_rvalid,
    input  logic [M-1:0]  imem_rdata,
    output logic          out_valid,
    output logic [M-1:0]  out_instr,
    output logic [M-1:0]  out_pcplus1,
    input  logic          out_ready,
    output logic [AW:0]   count
);

    localparam logic [AW:0]  FULL = (AW+1)'(DEPTH);
    localparam logic [M-1:0] ONE  = M'(1);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [M-1:0]    fpc_q, fpc_d;
    logic [M-1:0]    req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic [M-1:0]    instr_q [DEPTH];
    logic [M-1:0]    instr_d [DEPTH];
    logic [M-1:0]    pc1_q   [DEPTH];
    logic [M-1:0]    pc1_d   [DEPTH];

    logic            resp;
    logic            bypass;
    logic            bypass_take;
    logic            push;
    logic            pop;
    logic [M-1:0]    req_pc_plus1;

    assign req_pc_plus1 = req_pc_q + ONE;
    assign imem_addr    = fpc_q;
    assign count        = count_q;

    // Request, handshake and output path.
    always_comb begin
        imem_req = ~RST & (state_q == S_IDLE) & (count_q != FULL) & ~redirect;
        resp     = (state_q == S_WAIT) & imem_rvalid;
`ifdef FQ_BYPASS_EN
        bypass   = ~RST & resp & ~drop_q & ~redirect & (count_q == '0);
`else
        bypass   = 1'b0;
`endif
        // A bypassed response consumed by decode never enters storage.
        bypass_take = bypass & out_ready;
        push        = resp & ~drop_q & ~redirect & ~bypass_take;
        pop         = (count_q != '0) & out_ready & ~redirect;

        out_valid   = ~RST & ((count_q != '0) | bypass);
        if (RST) begin
            out_instr   = '0;
            out_pcplus1 = '0;
        end else if (bypass) begin
            out_instr   = imem_rdata;
            out_pcplus1 = req_pc_plus1;
        end else begin
            out_instr   = instr_q[rd_ptr_q];
            out_pcplus1 = pc1_q[rd_ptr_q];
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        fpc_d    = fpc_q;
        req_pc_d = req_pc_q;
        drop_d   = drop_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        instr_d  = instr_q;
        pc1_d    = pc1_q;

        if (redirect) begin
            fpc_d    = redirect_pc;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            // A read still in flight is marked so its response is discarded.
            if (state_q == S_WAIT) begin
                if (imem_rvalid) begin
                    state_d = S_IDLE;
                    drop_d  = 1'b0;
                end else begin
                    drop_d  = 1'b1;
                end
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (imem_req && imem_ack) begin
                        req_pc_d = fpc_q;
                        fpc_d    = fpc_q + ONE;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (push) begin
                instr_d[wr_ptr_q] = imem_rdata;
                pc1_d[wr_ptr_q]   = req_pc_plus1;
                wr_ptr_d          = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            fpc_q    <= RESET_PC;
            req_pc_q <= '0;
            drop_q   <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc1_q[i]   <= '0;
            end
        end else begin
            state_q  <= state_d;
            fpc_q    <= fpc_d;
            req_pc_q <= req_pc_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            instr_q  <= instr_d;
            pc1_q    <= pc1_d;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default build, no bypass).
// The bench plays instruction memory with a variable-latency response.
// Expected decode-side entries are pushed into a scoreboard queue as responses
// are delivered, and a separate monitor pops and compares on every consumed
// head entry.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        CLK = 1'b0;
    logic        RST;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pcplus1;
    logic        out_ready;
    logic [2:0]  count;

    fetch_queue #(
        .M(32),
        .DEPTH(DEPTH),
        .AW(2),
        .RESET_PC(RESET_PC)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rvalid(imem_rvalid),
        .imem_rdata(imem_rdata),
        .out_valid(out_valid),
        .out_instr(out_instr),
        .out_pcplus1(out_pcplus1),
        .out_ready(out_ready),
        .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc1;
    } ent_t;

    ent_t        expq[$];
    ent_t        staged;
    logic        staged_v;
    logic        pending;
    logic        p_stale;
    logic [31:0] p_addr;
    int          p_cnt;
    int          fix_delay;
    logic [31:0] fpc_m;
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] image(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: check registered state, drive inputs, check the
    // combinational response and advance the reference model.
    task automatic step(input logic rst, input logic rdy, input logic redir,
                        input logic [31:0] rpc, input logic ack, input logic force_rv);
        logic resp;
        logic exp_req;
        @(negedge CLK);
        if (staged_v) begin
            expq.push_back(staged);
            staged_v = 1'b0;
        end
        chk("count", 32'(count), 32'(expq.size()));
        chk("out_valid", 32'(out_valid), 32'(!RST && expq.size() != 0));

        RST         = rst;
        out_ready   = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        resp        = 1'b0;
        if (force_rv) begin
            imem_rvalid = 1'b1;
        end else if (pending) begin
            if (p_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = image(p_addr);
                resp        = 1'b1;
            end else begin
                p_cnt--;
            end
        end
        #1;

        if (rst) begin
            chk("rst_imem_req", 32'(imem_req), 32'h0);
            chk("rst_out_valid", 32'(out_valid), 32'h0);
            chk("rst_out_instr", out_instr, 32'h0);
            chk("rst_out_pcplus1", out_pcplus1, 32'h0);
            expq.delete();
            pending  = 1'b0;
            p_stale  = 1'b0;
            staged_v = 1'b0;
            fpc_m    = RESET_PC;
        end else begin
            exp_req = !pending && (expq.size() < DEPTH) && !redir;
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, fpc_m);
            if (resp) begin
                pending = 1'b0;
                if (!p_stale && !redir) begin
                    staged   = {image(p_addr), p_addr + 32'd1};
                    staged_v = 1'b1;
                end
            end
            if (exp_req && ack) begin
                pending = 1'b1;
                p_stale = 1'b0;
                p_addr  = fpc_m;
                p_cnt   = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
                fpc_m   = fpc_m + 32'd1;
            end
            if (redir) begin
                expq.delete();
                fpc_m = rpc;
                if (pending) p_stale = 1'b1;
            end
        end
    endtask

    // Monitor: every consumed head entry must match the scoreboard front.
    initial begin
        ent_t e;
        forever begin
            @(negedge CLK);
            #2;
            if (!RST && out_valid && out_ready && !redirect) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL pop_unexpected: got instr %0h pc1 %0h expected no entry",
                             out_instr, out_pcplus1);
                end else begin
                    e = expq.pop_front();
                    chk("out_instr", out_instr, e.instr);
                    chk("out_pcplus1", out_pcplus1, e.pc1);
                end
            end
        end
    end

    initial begin
        logic found;
        RST = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_ack = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; out_ready = 1'b0;
        pending = 1'b0; p_stale = 1'b0; p_addr = '0; p_cnt = 0;
        staged_v = 1'b0; staged = '0; fpc_m = RESET_PC; fix_delay = 0;

        repeat (3) step(1, 0, 0, 0, 0, 0);

        // Free run, immediate ack, one-cycle response.
        repeat (16) step(0, 1, 0, 0, 1, 0);

        // Stall from reset: queue fills and fetch holds at address 4.
        repeat (2) step(1, 0, 0, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0, 1, 0);
        chk("stall_count", 32'(count), 32'(DEPTH));
        chk("stall_req", 32'(imem_req), 32'h0);
        chk("stall_addr", imem_addr, 32'h4);
        repeat (12) step(0, 1, 0, 0, 1, 0);

        // Redirect to 0x40 while a slow read is outstanding.
        fix_delay = 3;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 1, 0, 0, 1, 0);
            if (pending && !p_stale) found = 1'b1;
        end
        chk("wait_reached", 32'(found), 32'h1);
        fix_delay = 0;
        step(0, 1, 1, 32'h40, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("redir_addr", imem_addr, 32'h40);
        repeat (14) step(0, 1, 0, 0, 1, 0);

        // Redirect to 0x80 in the response cycle with two entries queued.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (pending && !p_stale && p_cnt == 0 && (expq.size() + int'(staged_v)) == 2)
                found = 1'b1;
            else
                step(0, 0, 0, 0, 1, 0);
        end
        chk("two_entries_reached", 32'(found), 32'h1);
        step(0, 0, 1, 32'h80, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("redir2_count", 32'(count), 32'h0);
        chk("redir2_addr", imem_addr, 32'h80);
        repeat (10) step(0, 1, 0, 0, 1, 0);

        // Fill, then pop and refill around full across pointer wrap.
        repeat (20) step(0, 0, 0, 0, 1, 0);
        repeat (60) step(0, 1'($urandom_range(0, 1)), 0, 0, 1, 0);

        // Reset while waiting; the response lands the cycle after reset.
        fix_delay = 1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            step(0, 1, 0, 0, 1, 0);
            if (pending && !p_stale) found = 1'b1;
        end
        chk("wait_before_reset", 32'(found), 32'h1);
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        chk("post_rst_count", 32'(count), 32'h0);
        chk("post_rst_addr", imem_addr, RESET_PC);
        fix_delay = 0;
        repeat (8) step(0, 1, 0, 0, 1, 0);

        // Randomized traffic.
        fix_delay = -1;
        for (int i = 0; i < 2000; i++) begin
            logic        r_rst;
            logic        r_redir;
            logic [31:0] r_pc;
            r_rst   = ($urandom_range(0, 199) == 0);
            r_redir = ($urandom_range(0, 99) < 3);
            r_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom;
            step(r_rst, ($urandom_range(0, 9) < 7), r_redir, r_pc,
                 ($urandom_range(0, 9) < 7), 0);
        end
        repeat (20) step(0, 1, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
